// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Purpose : Shared definitions for the ID/EX operand stage.
//           - Datapath widths (XLEN, RADDR).
//           - ALU operation codes.
//           - Control bundle carried from ID into EX.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN  = 32;
   localparam int RADDR = 5;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_SLL = 4'b0010,
      ALU_XOR = 4'b0011,
      ALU_SRL = 4'b0100,
      ALU_SRA = 4'b0101,
      ALU_OR  = 4'b0110,
      ALU_AND = 4'b0111,
      ALU_BLT = 4'b1000,
      ALU_BGE = 4'b1001
   } alu_op_e;

   // Control bits that are cleared when a bubble is inserted.
   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic branch;
      logic alu_src;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage_if
// Purpose : Bundles every non-clock/reset signal of the ID/EX operand stage.
// Signals :
//   ID side      : valid_i, rs1/rs2_data_i, imm_i, rs1/rs2/rd_addr_i,
//                  alu_ctrl_i, alu_src_i, reg_write_i, mem_read_i,
//                  mem_write_i, mem_to_reg_i, branch_i
//   Pipeline ctl : stall_i, flush_i
//   Bypass       : exmem_reg_write_i/rd_i/data_i, memwb_reg_write_i/rd_i/data_i
//   EX side      : data1_o, data2_o, ALUCtrl_o, store_data_o, rd_addr_o,
//                  valid_o, reg_write_o, mem_read_o, mem_write_o,
//                  mem_to_reg_o, branch_o, load_use_stall_o
// Modports: slave  - the operand stage itself
//           master - the surrounding pipeline (drives the *_i signals)
// -----------------------------------------------------------------------------
interface id_ex_operand_stage_if;
   import riscv_pkg::*;

   logic              valid_i;
   logic [XLEN-1:0]   rs1_data_i;
   logic [XLEN-1:0]   rs2_data_i;
   logic [XLEN-1:0]   imm_i;
   logic [RADDR-1:0]  rs1_addr_i;
   logic [RADDR-1:0]  rs2_addr_i;
   logic [RADDR-1:0]  rd_addr_i;
   logic [3:0]        alu_ctrl_i;
   logic              alu_src_i;
   logic              reg_write_i;
   logic              mem_read_i;
   logic              mem_write_i;
   logic              mem_to_reg_i;
   logic              branch_i;
   logic              stall_i;
   logic              flush_i;
   logic              exmem_reg_write_i;
   logic [RADDR-1:0]  exmem_rd_i;
   logic [XLEN-1:0]   exmem_data_i;
   logic              memwb_reg_write_i;
   logic [RADDR-1:0]  memwb_rd_i;
   logic [XLEN-1:0]   memwb_data_i;

   logic [XLEN-1:0]   data1_o;
   logic [XLEN-1:0]   data2_o;
   logic [3:0]        ALUCtrl_o;
   logic [XLEN-1:0]   store_data_o;
   logic [RADDR-1:0]  rd_addr_o;
   logic              valid_o;
   logic              reg_write_o;
   logic              mem_read_o;
   logic              mem_write_o;
   logic              mem_to_reg_o;
   logic              branch_o;
   logic              load_use_stall_o;

   modport slave (
      input  valid_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i,
             rd_addr_i, alu_ctrl_i, alu_src_i, reg_write_i, mem_read_i,
             mem_write_i, mem_to_reg_i, branch_i, stall_i, flush_i,
             exmem_reg_write_i, exmem_rd_i, exmem_data_i,
             memwb_reg_write_i, memwb_rd_i, memwb_data_i,
      output data1_o, data2_o, ALUCtrl_o, store_data_o, rd_addr_o, valid_o,
             reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_o,
             load_use_stall_o
   );

   modport master (
      output valid_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i,
             rd_addr_i, alu_ctrl_i, alu_src_i, reg_write_i, mem_read_i,
             mem_write_i, mem_to_reg_i, branch_i, stall_i, flush_i,
             exmem_reg_write_i, exmem_rd_i, exmem_data_i,
             memwb_reg_write_i, memwb_rd_i, memwb_data_i,
      input  data1_o, data2_o, ALUCtrl_o, store_data_o, rd_addr_o, valid_o,
             reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_o,
             load_use_stall_o
   );

endinterface

// File: rtl/fwd_mux.sv
// -----------------------------------------------------------------------------
// fwd_mux
// Purpose : Operand bypass for one source register. Compares the registered
//           source address against the EX/MEM and MEM/WB destinations and
//           selects the youngest matching result, else the regfile value.
// Ports   :
//   i_bypass_en   in  1      0 forces the regfile value through
//   i_rs_addr     in  RADDR  registered source address
//   i_rs_data     in  XLEN   registered regfile read data
//   i_exmem_we    in  1      EX/MEM writes its rd
//   i_exmem_rd    in  RADDR  EX/MEM destination
//   i_exmem_data  in  XLEN   EX/MEM ALU result
//   i_memwb_we    in  1      MEM/WB writes its rd
//   i_memwb_rd    in  RADDR  MEM/WB destination
//   i_memwb_data  in  XLEN   MEM/WB writeback value
//   o_data        out XLEN   forwarded operand
// -----------------------------------------------------------------------------
module fwd_mux
   import riscv_pkg::*;
(
   input  logic             i_bypass_en,
   input  logic [RADDR-1:0] i_rs_addr,
   input  logic [XLEN-1:0]  i_rs_data,
   input  logic             i_exmem_we,
   input  logic [RADDR-1:0] i_exmem_rd,
   input  logic [XLEN-1:0]  i_exmem_data,
   input  logic             i_memwb_we,
   input  logic [RADDR-1:0] i_memwb_rd,
   input  logic [XLEN-1:0]  i_memwb_data,
   output logic [XLEN-1:0]  o_data
);

   logic w_exmem_hit;
   logic w_memwb_hit;

   // x0 is hard-wired to zero, so a write targeting it must never be bypassed.
   assign w_exmem_hit = i_bypass_en & i_exmem_we & (i_exmem_rd != '0) & (i_exmem_rd == i_rs_addr);
   assign w_memwb_hit = i_bypass_en & i_memwb_we & (i_memwb_rd != '0) & (i_memwb_rd == i_rs_addr);

   // EX/MEM holds the younger result, so it is checked first.
   always_comb begin
      o_data = i_rs_data;
      if (w_exmem_hit) begin
         o_data = i_exmem_data;
      end else if (w_memwb_hit) begin
         o_data = i_memwb_data;
      end
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
// Purpose : ID/EX pipeline register plus ALU operand issue.
//           - Latches decoded ID fields every cycle (1-cycle ID->EX latency).
//           - Forwards EX/MEM and MEM/WB results into both operands.
//           - Flags load-use hazards so ID can hold while a bubble goes in.
//           Update priority at each edge: flush > stall > load-use bubble > load.
// Ports   :
//   clk_i   in  1  clock, rising edge
//   rst_i   in  1  asynchronous reset, active low
//   bus     slave modport of id_ex_operand_stage_if (ID fields, stall/flush,
//           bypass sources, EX operands/controls, load_use_stall_o)
// Build option:
//   EX_BYPASS_EN  defined     : EX/MEM and MEM/WB forwarding enabled.
//                 not defined : operands come straight from the registered
//                               regfile data; bypass inputs are ignored and
//                               upstream logic must stall on every RAW case.
// -----------------------------------------------------------------------------
module id_ex_operand_stage
   import riscv_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   id_ex_operand_stage_if.slave  bus
);

   // ---------------------------------------------------------------- state
   logic             r_valid;
   ctrl_t            r_ctrl;
   alu_op_e          r_alu_ctrl;
   logic [XLEN-1:0]  r_rs1_data;
   logic [XLEN-1:0]  r_rs2_data;
   logic [XLEN-1:0]  r_imm;
   logic [RADDR-1:0] r_rs1_addr;
   logic [RADDR-1:0] r_rs2_addr;
   logic [RADDR-1:0] r_rd;

   logic             w_load_use;
   logic             w_bypass_en;
   logic [RADDR-1:0] w_rs_addr [2];
   logic [XLEN-1:0]  w_rs_data [2];
   logic [XLEN-1:0]  w_fwd     [2];

`ifdef EX_BYPASS_EN
   assign w_bypass_en = 1'b1;
`else
   assign w_bypass_en = 1'b0;
`endif

   // A load in EX whose rd is read by the instruction now in ID cannot be
   // forwarded in time. A flush squashes ID anyway, so no hold is needed then.
   assign w_load_use = r_valid & r_ctrl.mem_read & (r_rd != '0) & bus.valid_i
                     & ((r_rd == bus.rs1_addr_i) | (r_rd == bus.rs2_addr_i))
                     & ~bus.flush_i;

   // ------------------------------------------------------- pipeline register
   // Bubbles clear valid and the control bundle only; data fields keep their
   // last values since nothing downstream looks at them without valid.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_valid    <= 1'b0;
         r_ctrl     <= CTRL_BUBBLE;
         r_alu_ctrl <= ALU_ADD;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_imm      <= '0;
         r_rs1_addr <= '0;
         r_rs2_addr <= '0;
         r_rd       <= '0;
      end else if (bus.flush_i) begin
         r_valid <= 1'b0;
         r_ctrl  <= CTRL_BUBBLE;
      end else if (bus.stall_i) begin
         // hold everything, including a bubble already in place
      end else if (w_load_use) begin
         r_valid <= 1'b0;
         r_ctrl  <= CTRL_BUBBLE;
      end else begin
         r_valid           <= bus.valid_i;
         r_ctrl.reg_write  <= bus.reg_write_i;
         r_ctrl.mem_read   <= bus.mem_read_i;
         r_ctrl.mem_write  <= bus.mem_write_i;
         r_ctrl.mem_to_reg <= bus.mem_to_reg_i;
         r_ctrl.branch     <= bus.branch_i;
         r_ctrl.alu_src    <= bus.alu_src_i;
         r_alu_ctrl        <= alu_op_e'(bus.alu_ctrl_i);
         r_rs1_data        <= bus.rs1_data_i;
         r_rs2_data        <= bus.rs2_data_i;
         r_imm             <= bus.imm_i;
         r_rs1_addr        <= bus.rs1_addr_i;
         r_rs2_addr        <= bus.rs2_addr_i;
         r_rd              <= bus.rd_addr_i;
      end
   end

   // ---------------------------------------------------------- forwarding
   // Index 0 = rs1, index 1 = rs2.
   assign w_rs_addr[0] = r_rs1_addr;
   assign w_rs_addr[1] = r_rs2_addr;
   assign w_rs_data[0] = r_rs1_data;
   assign w_rs_data[1] = r_rs2_data;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         fwd_mux u_fwd_mux (
            .i_bypass_en  (w_bypass_en),
            .i_rs_addr    (w_rs_addr[gi]),
            .i_rs_data    (w_rs_data[gi]),
            .i_exmem_we   (bus.exmem_reg_write_i),
            .i_exmem_rd   (bus.exmem_rd_i),
            .i_exmem_data (bus.exmem_data_i),
            .i_memwb_we   (bus.memwb_reg_write_i),
            .i_memwb_rd   (bus.memwb_rd_i),
            .i_memwb_data (bus.memwb_data_i),
            .o_data       (w_fwd[gi])
         );
      end
   endgenerate

   // ------------------------------------------------------------- outputs
   assign bus.data1_o          = w_fwd[0];
   assign bus.data2_o          = r_ctrl.alu_src ? r_imm : w_fwd[1];
   assign bus.store_data_o     = w_fwd[1];
   assign bus.ALUCtrl_o        = r_alu_ctrl;
   assign bus.rd_addr_o        = r_rd;
   assign bus.valid_o          = r_valid;
   assign bus.reg_write_o      = r_ctrl.reg_write;
   assign bus.mem_read_o       = r_ctrl.mem_read;
   assign bus.mem_write_o      = r_ctrl.mem_write;
   assign bus.mem_to_reg_o     = r_ctrl.mem_to_reg;
   assign bus.branch_o         = r_ctrl.branch;
   assign bus.load_use_stall_o = w_load_use;

endmodule
